dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the slave end of the CPU memory-stage load/store port.
//  - Accepts one request at a time (valid/ready) and waits a programmable number of cycles.
//  - Performs byte, half or word access on an internal word-organised array.
//  - Returns read data or a completion through a valid/ready response channel.
//  - Sits between the pipeline memory stage and on-chip SRAM; models real memory latency.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; byte address range 0..4*DEPTH_WORDS-1
//  WAIT_CYCLES  2     extra cycles between request accept and access commit (0..15)
// PORTS
//  clk_i         in   1   clock, rising edge
//  reset_i       in   1   reset, asynchronous, active-low
//  req_valid_i   in   1   request valid
//  req_ready_o   out  1   responder can accept a request
//  req_we_i      in   1   1=store, 0=load
//  req_addr_i    in   32  byte address
//  req_wdata_i   in   32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
//  req_funct3_i  in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  rsp_valid_o   out  1   response valid
//  rsp_ready_i   in   1   requester accepts response
//  rsp_rdata_o   out  32  load result (extended); 0 for stores and errors
//  rsp_err_o     out  1   access error (bad funct3, out of range, misaligned if enabled)
//  busy_o        out  1   request outstanding (state != IDLE)
// BEHAVIOUR
//  - Reset (reset_i=0, async): state=IDLE, counter=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
//    - Also during reset: busy_o=0, req_ready_o=0 while reset is asserted.
//    - Memory array is not cleared.
//  - FSM IDLE:
//    - req_ready_o=1.
//    - On req_valid_i & req_ready_o, capture we/addr/wdata/funct3 and load counter=WAIT_CYCLES.
//    - Then go to WAIT, or to ACCESS if WAIT_CYCLES==0.
//  - FSM WAIT:
//    - req_ready_o=0. Counter decrements each cycle; at 1 go to ACCESS.
//  - FSM ACCESS (one cycle):
//    - Evaluate the error condition.
//    - If no error, commit the store byte lanes or register the extended load data.
//    - Go to RESP.
//  - FSM RESP:
//    - rsp_valid_o=1; rdata and err are held stable until rsp_ready_i=1.
//    - On handshake: rsp_valid_o clears and the FSM goes to IDLE.
//    - No new request is accepted in the same cycle.
//  - Latency: accept edge to rsp_valid_o high = WAIT_CYCLES+2 cycles. Throughput: 1 request per WAIT_CYCLES+3 cycles minimum.
//  - Lane rules:
//    - B/BU select byte addr[1:0]; H/HU select half addr[1].
//    - B/H sign-extend; BU/HU zero-extend; W passes through.
//    - Stores: funct3 000/001/010 only; other bytes of the word are unchanged.
//  - Errors (rsp_err_o=1, no write, rdata=0):
//    - funct3 in {011,110,111}, or funct3 1xx with req_we_i=1.
//    - Word index addr[31:2] >= DEPTH_WORDS.
//  - Boundary: last word (addr 4*DEPTH_WORDS-4) is valid; the next word errors. No wrap-around.
//  - req_* inputs are ignored outside IDLE; no queuing.
//  - Reset mid-operation:
//    - In WAIT, the pending store is discarded (never committed).
//    - In RESP, the pending response is dropped.
// CONFIGURATION
//  - DMEM_MISALIGN_TRAP_EN defined:
//    - H/HU with addr[0]=1, or W with addr[1:0]!=0, gives rsp_err_o=1, no write, rdata=0.
//  - Undefined:
//    - Misaligned low bits are ignored (H uses addr[1], W uses the whole word); never an error.
// TESTING
//  1. WAIT_CYCLES=2: SW 0xDEADBEEF @0x10, then LW @0x10
//     -> rsp_valid 4 cycles after each accept; LW rdata=0xDEADBEEF, err=0.
//  2. After 1: SB wdata=0x80 @0x13; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080;
//     LW @0x10 -> 0x80ADBEEF.
//  3. LH @0x12 after 2 -> 0xFFFF80AD; hold rsp_ready_i=0 for 5 cycles
//     -> rsp_valid/rdata stable, req_ready_o=0, busy_o=1 throughout.
//  4. DEPTH_WORDS=1024: SW 0x1 @0x1000 -> err=1, rdata=0; then LW @0xFFC returns its prior value.
//     funct3=011 load -> err=1.
//  5. LW @0x12: with DMEM_MISALIGN_TRAP_EN -> err=1, rdata=0; without -> err=0, rdata=0x80ADBEEF.
//  6. SW 0x12345678 @0x10, reset_i low for 1 cycle during WAIT
//     -> all outputs at reset values immediately; subsequent LW @0x10 returns 0x80ADBEEF.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait latency, valid/ready response.
// Define DMEM_MISALIGN_TRAP_EN to turn misaligned H/HU/W accesses into error responses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] widx;
  logic [31:0]   word_num;
  logic          in_range;
  logic          funct_bad;
  logic          misalign;
  logic          err;
  logic [31:0]   rword;
  logic [3:0]    wmask;
  logic [31:0]   wlanes;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   store_mask = 4'b0001 << a;
      2'b01:   store_mask = a[1] ? 4'b1100 : 4'b0011;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  assign accept      = req_valid_i & req_ready_o;
  assign req_ready_o = (state == S_IDLE) & reset_i;
  assign busy_o      = (state != S_IDLE);
  assign rsp_valid_o = (state == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign widx     = addr_q[AW+1:2];
  assign word_num = {2'b00, addr_q[31:2]};
  assign in_range = word_num < $unsigned(32'(DEPTH_WORDS));
  assign rword    = mem[widx];
  assign wmask    = store_mask(addr_q[1:0], funct3_q[1:0]);
  assign wlanes   = (funct3_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} :
                    (funct3_q[1:0] == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;

  always_comb begin
    funct_bad = 1'b1;
    case (funct3_q)
      3'b000, 3'b001, 3'b010: funct_bad = 1'b0;
      3'b100, 3'b101:         funct_bad = we_q;
      default:                funct_bad = 1'b1;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (funct3_q)
      3'b001, 3'b101: misalign = addr_q[0];
      3'b010:         misalign = |addr_q[1:0];
      default:        misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign err = funct_bad | ~in_range | misalign;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt <= 4'd1) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   if (rsp_ready_i) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control and response registers; response holds until the handshake
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE:   if (accept) cnt <= 4'(WAIT_CYCLES);
        S_WAIT:   cnt <= cnt - 4'd1;
        S_ACCESS: begin
          err_q   <= err;
          rdata_q <= (err || we_q) ? 32'd0 : load_ext(rword, addr_q[1:0], funct3_q);
        end
        default: ;
      endcase
    end
  end

  // Request capture and array write; no reset on datapath storage
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q     <= req_we_i;
      addr_q   <= req_addr_i;
      wdata_q  <= req_wdata_i;
      funct3_q <= req_funct3_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == S_ACCESS && we_q && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[widx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
module tb_dmem_responder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_funct3_i(req_funct3_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a request and returns #1 after the accept edge
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3);
    int n;
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_funct3_i = f3;
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("req_ready_before_accept", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  // Edges are counted including the accept edge; holds rsp_ready low for 'hold' cycles
  task automatic collect(input int hold, output logic [31:0] r, output logic e, output int l);
    logic [31:0] first_rd;
    l = 1;
    while (!rsp_valid_o && l < 50) begin
      @(posedge clk_i);
      #1;
      l++;
    end
    r = rsp_rdata_o;
    e = rsp_err_o;
    first_rd = rsp_rdata_o;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_i);
      chk("hold_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("hold_rdata", rsp_rdata_o, first_rd);
      chk("hold_req_ready", {31'd0, req_ready_o}, 32'd0);
      chk("hold_busy", {31'd0, busy_o}, 32'd1);
    end
    req_valid_i = 1'b0;
    @(negedge clk_i);
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, output logic [31:0] r, output logic e, output int l);
    issue(we, addr, wdata, f3);
    collect(0, r, e, l);
  endtask

  initial begin
    reset_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_funct3_i = 3'b000; rsp_ready_i = 1'b0;

    #12;
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_err", {31'd0, rsp_err_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1 chk("idle_req_ready", {31'd0, req_ready_o}, 32'd1);

    // Word store then load, with latency
    xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat);
    chk("sw_lat", lat, 32'd4);
    chk("sw_err", {31'd0, er}, 32'd0);
    chk("sw_rdata", rd, 32'd0);
    chk("post_hs_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("post_hs_req_ready", {31'd0, req_ready_o}, 32'd1);
    xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    chk("lw_lat", lat, 32'd4);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", {31'd0, er}, 32'd0);

    // Byte store and sub-word loads
    xact(1'b1, 32'h13, 32'h80, 3'b000, rd, er, lat);
    chk("sb_err", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h13, 32'h0, 3'b000, rd, er, lat);
    chk("lb_13", rd, 32'hFFFFFF80);
    xact(1'b0, 32'h13, 32'h0, 3'b100, rd, er, lat);
    chk("lbu_13", rd, 32'h00000080);
    xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    chk("lw_after_sb", rd, 32'h80ADBEEF);
    xact(1'b0, 32'h10, 32'h0, 3'b000, rd, er, lat);
    chk("lb_10", rd, 32'hFFFFFFEF);
    xact(1'b0, 32'h11, 32'h0, 3'b100, rd, er, lat);
    chk("lbu_11", rd, 32'h000000BE);

    // Halfword load with response back-pressure; a stray store request is offered meanwhile
    issue(1'b0, 32'h12, 32'h0, 3'b001);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h10;
    req_wdata_i = 32'h0; req_funct3_i = 3'b010;
    collect(5, rd, er, lat);
    chk("lh_12", rd, 32'hFFFF80AD);
    chk("lh_lat", lat, 32'd4);
    xact(1'b0, 32'h12, 32'h0, 3'b101, rd, er, lat);
    chk("lhu_12", rd, 32'h000080AD);
    xact(1'b1, 32'h16, 32'hABCD1234, 3'b001, rd, er, lat);
    xact(1'b0, 32'h16, 32'h0, 3'b101, rd, er, lat);
    chk("sh_lhu_16", rd, 32'h00001234);

    // Range boundary and illegal funct3
    xact(1'b1, 32'hFFC, 32'hCAFEF00D, 3'b010, rd, er, lat);
    chk("sw_last_err", {31'd0, er}, 32'd0);
    xact(1'b1, 32'h1000, 32'h1, 3'b010, rd, er, lat);
    chk("sw_oob_err", {31'd0, er}, 32'd1);
    chk("sw_oob_rdata", rd, 32'd0);
    xact(1'b0, 32'hFFC, 32'h0, 3'b010, rd, er, lat);
    chk("lw_last", rd, 32'hCAFEF00D);
    chk("lw_last_err", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h1000, 32'h0, 3'b010, rd, er, lat);
    chk("lw_oob_err", {31'd0, er}, 32'd1);
    chk("lw_oob_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat);
    chk("f3_011_err", {31'd0, er}, 32'd1);
    chk("f3_011_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 3'b110, rd, er, lat);
    chk("f3_110_err", {31'd0, er}, 32'd1);
    xact(1'b1, 32'h10, 32'h0, 3'b100, rd, er, lat);
    chk("sbu_err", {31'd0, er}, 32'd1);
    xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    chk("lw_unchanged", rd, 32'h80ADBEEF);

    // Misaligned word load
    xact(1'b0, 32'h12, 32'h0, 3'b010, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw_mis_err", {31'd0, er}, 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
`else
    chk("lw_mis_err", {31'd0, er}, 32'd0);
    chk("lw_mis_rdata", rd, 32'h80ADBEEF);
`endif

    // Reset while a store is waiting
    issue(1'b1, 32'h10, 32'h12345678, 3'b010);
    reset_i = 1'b0;
    #1;
    chk("midrst_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("midrst_rdata", rsp_rdata_o, 32'd0);
    chk("midrst_err", {31'd0, rsp_err_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    chk("lw_after_midrst", rd, 32'h80ADBEEF);
    chk("lw_after_midrst_err", {31'd0, er}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
